// File: rtl/fft_peak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_pkg
//  Description : Shared types and helpers for the FFT peak finder.
//                - state_t   : scan FSM state encoding
//                - mag_width : lossless squared-magnitude width for a given
//                              component width
//                - bin_slice : LSB position of bin k inside the packed frame
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_peak_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Two squares of a signed half_w value each fit in 2*half_w-1 bits as
    // unsigned; their sum needs one more, plus headroom for the signed
    // intermediate used while squaring.
    function automatic int mag_width(input int half_w);
        return 2 * half_w + 1;
    endfunction

    // Bin k occupies [k*2*half_w +: 2*half_w] of the packed frame.
    function automatic int bin_slice(input int k, input int half_w);
        return k * 2 * half_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_peak_finder_bin_magnitude.sv
`default_nettype none
// ============================================================================
//  Module      : bin_magnitude
//  Description : Combinational exact squared magnitude re^2 + im^2 of one
//                complex bin.
//  Ports       : bin [2*HALF_W-1:0] - {re, im}, two's complement
//                mag [MAG_W-1:0]    - unsigned re^2 + im^2, no truncation
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_magnitude #(
    parameter int HALF_W = 16,
    parameter int MAG_W  = 2 * HALF_W + 1
) (
    input  logic [2*HALF_W-1:0] bin,
    output logic [MAG_W-1:0]    mag
);

    logic signed [HALF_W-1:0] w_re;
    logic signed [HALF_W-1:0] w_im;
    logic signed [MAG_W-1:0]  w_re_ext;
    logic signed [MAG_W-1:0]  w_im_ext;
    logic signed [MAG_W-1:0]  w_sum;

    assign w_re = bin[2*HALF_W-1:HALF_W];
    assign w_im = bin[HALF_W-1:0];

    // Sign-extend to the full magnitude width before squaring so the
    // products and their sum are evaluated without overflow. The largest
    // sum, 2^(2*HALF_W-1), is still positive in MAG_W signed bits.
    assign w_re_ext = {{(MAG_W-HALF_W){w_re[HALF_W-1]}}, w_re};
    assign w_im_ext = {{(MAG_W-HALF_W){w_im[HALF_W-1]}}, w_im};
    assign w_sum    = (w_re_ext * w_re_ext) + (w_im_ext * w_im_ext);

    assign mag = $unsigned(w_sum);

endmodule
`default_nettype wire

// File: rtl/fft_peak_finder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_finder
//  Description : Accepts one frame of N_BINS complex bins, scans it LANES
//                bins per cycle and reports the index and squared magnitude
//                of the largest bin together with a threshold flag.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready/in_data/threshold - frame input handshake
//                out_valid/out_ready                 - result handshake
//                peak_idx, peak_mag, above_thr       - registered result
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_finder
    import fft_peak_pkg::*;
#(
    parameter int N_BINS  = 16,
    parameter int HALF_W  = 16,
    parameter int LANES   = 1,
    parameter int SKIP_DC = 0,
    parameter int IDX_W   = $clog2(N_BINS),
    parameter int MAG_W   = mag_width(HALF_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_BINS*2*HALF_W-1:0] in_data,
    input  logic [MAG_W-1:0]           threshold,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           peak_idx,
    output logic [MAG_W-1:0]           peak_mag,
    output logic                       above_thr
);

    localparam int         c_SCANS = N_BINS / LANES;
    localparam int         c_CNT_W = (c_SCANS > 1) ? $clog2(c_SCANS) : 1;
    localparam logic [IDX_W-1:0] c_FIRST = (SKIP_DC != 0) ? IDX_W'(1) : '0;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2*HALF_W-1:0]   r_bins [N_BINS];
    logic [2*HALF_W-1:0]   w_in_bins [N_BINS];
    logic [MAG_W-1:0]      r_thr;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [MAG_W-1:0]      r_best_mag;
    logic [IDX_W-1:0]      r_best_idx;

    logic [IDX_W-1:0]      w_lane_idx [LANES];
    logic [MAG_W-1:0]      w_lane_mag [LANES];
    logic [LANES-1:0]      w_lane_ok;
    logic [MAG_W-1:0]      w_red_mag;
    logic [IDX_W-1:0]      w_red_idx;
    logic                  w_last;
    logic                  w_accept;

    // ------------------------------------------------------------------
    // Frame unpacking and per-lane magnitude evaluation
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_BINS; k++) begin : g_unpack
        assign w_in_bins[k] = in_data[bin_slice(k, HALF_W) +: 2*HALF_W];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_idx[l] = IDX_W'(r_cnt * LANES) + IDX_W'(l);
        // Bin 0 is never a candidate when DC is excluded.
        assign w_lane_ok[l]  = (SKIP_DC == 0) || (w_lane_idx[l] != '0);

        bin_magnitude #(
            .HALF_W (HALF_W),
            .MAG_W  (MAG_W)
        ) u_mag (
            .bin (r_bins[w_lane_idx[l]]),
            .mag (w_lane_mag[l])
        );
    end

    // Lanes fold in ascending index order; strict compare keeps the lower
    // index on ties, both within a cycle and across cycles.
    always_comb begin
        w_red_mag = r_best_mag;
        w_red_idx = r_best_idx;
        for (int l = 0; l < LANES; l++) begin
            if (w_lane_ok[l] && (w_lane_mag[l] > w_red_mag)) begin
                w_red_mag = w_lane_mag[l];
                w_red_idx = w_lane_idx[l];
            end
        end
    end

    assign w_last   = (r_cnt == c_CNT_W'(c_SCANS - 1));
    assign w_accept = (r_state == IDLE) && in_valid;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = SCAN;
            SCAN:    if (w_last)    w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_BINS; k++) begin
                r_bins[k] <= '0;
            end
            r_thr      <= '0;
            r_cnt      <= '0;
            r_best_mag <= '0;
            r_best_idx <= '0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            above_thr  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bins     <= w_in_bins;
                r_thr      <= threshold;
                r_cnt      <= '0;
                r_best_mag <= '0;
                r_best_idx <= c_FIRST;
            end else if (r_state == SCAN) begin
                r_cnt      <= r_cnt + c_CNT_W'(1);
                r_best_mag <= w_red_mag;
                r_best_idx <= w_red_idx;
                if (w_last) begin
                    peak_idx  <= w_red_idx;
                    peak_mag  <= w_red_mag;
                    above_thr <= (w_red_mag > r_thr);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_finder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_peak_finder
//  Description : Directed self-checking bench. Three instances share clock,
//                reset, frame data, threshold and out_ready:
//                  dut 0 : LANES=1, SKIP_DC=0
//                  dut 1 : LANES=4, SKIP_DC=0
//                  dut 2 : LANES=1, SKIP_DC=1
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_peak_finder;

    logic               clk;
    logic               rst;
    logic [511:0]       in_data;
    logic [32:0]        threshold;
    logic               out_ready;
    logic [2:0]         iv;
    logic [2:0]         ir;
    logic [2:0]         ov;
    logic [2:0]         abv;
    logic [2:0][3:0]    pidx;
    logic [2:0][32:0]   pmag;

    int n_total;
    int n_pass;

    fft_peak_finder #(.N_BINS(16), .HALF_W(16), .LANES(1), .SKIP_DC(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(in_data), .threshold(threshold), .out_valid(ov[0]),
        .out_ready(out_ready), .peak_idx(pidx[0]), .peak_mag(pmag[0]),
        .above_thr(abv[0]));

    fft_peak_finder #(.N_BINS(16), .HALF_W(16), .LANES(4), .SKIP_DC(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(in_data), .threshold(threshold), .out_valid(ov[1]),
        .out_ready(out_ready), .peak_idx(pidx[1]), .peak_mag(pmag[1]),
        .above_thr(abv[1]));

    fft_peak_finder #(.N_BINS(16), .HALF_W(16), .LANES(1), .SKIP_DC(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(in_data), .threshold(threshold), .out_valid(ov[2]),
        .out_ready(out_ready), .peak_idx(pidx[2]), .peak_mag(pmag[2]),
        .above_thr(abv[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bin(input int k, input int re, input int im);
        logic [15:0] r16;
        logic [15:0] i16;
        r16 = re[15:0];
        i16 = im[15:0];
        in_data[k*32 +: 32] = {r16, i16};
    endtask

    task automatic fill(input int re, input int im);
        for (int k = 0; k < 16; k++) set_bin(k, re, im);
    endtask

    // Present the frame, then scribble on in_data/threshold while the DUT
    // is busy; the captured copy must be the one that is scanned.
    task automatic run_frame(input string tag, input int d, input int exp_lat,
                             input logic [3:0] e_idx, input logic [32:0] e_mag,
                             input logic e_abv);
        int cyc;
        iv[d] = 1'b1;
        step();
        iv[d]     = 1'b0;
        in_data   = ~in_data;
        threshold = ~threshold;
        chk({tag, "_busy"}, ir[d], 1'b0);
        cyc = 0;
        while (!ov[d] && cyc < 100) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_idx"}, pidx[d], e_idx);
        chk({tag, "_mag"}, pmag[d], e_mag);
        chk({tag, "_thr"}, abv[d], e_abv);
    endtask

    task automatic release_result(input string tag, input int d);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ov_clear"}, ov[d], 1'b0);
        chk({tag, "_ready_back"}, ir[d], 1'b1);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        iv        = '0;
        out_ready = 1'b0;
        in_data   = '0;
        threshold = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_in_ready",  ir[0],   1'b1);
        chk("rst_out_valid", ov[0],   1'b0);
        chk("rst_peak_idx",  pidx[0], 4'd0);
        chk("rst_peak_mag",  pmag[0], 33'd0);
        chk("rst_above_thr", abv[0],  1'b0);

        // Basic scan: bin 5 = (100,-50) -> 12500, others (10,10) -> 200
        fill(10, 10);
        set_bin(5, 100, -50);
        threshold = 33'd0;
        run_frame("basic", 0, 16, 4'd5, 33'd12500, 1'b1);
        release_result("basic", 0);

        // All-zero frame with an all-ones threshold
        in_data   = '0;
        threshold = '1;
        run_frame("zero", 0, 16, 4'd0, 33'd0, 1'b0);
        release_result("zero", 0);

        // Tie: bins 3 and 9 equal, lowest index wins
        in_data = '0;
        set_bin(3, 200, 0);
        set_bin(9, 200, 0);
        threshold = 33'd0;
        run_frame("tie", 0, 16, 4'd3, 33'd40000, 1'b1);
        release_result("tie", 0);

        // Extremes, four lanes: bin 15 = (-32768,-32768) -> 2^31
        fill(32767, 0);
        set_bin(15, -32768, -32768);
        threshold = 33'd0;
        run_frame("extreme", 1, 4, 4'd15, 33'd2147483648, 1'b1);
        release_result("extreme", 1);

        // DC excluded; threshold equal to the peak is not exceeded
        in_data = '0;
        set_bin(0, 1000, 0);
        set_bin(7, 3, 4);
        threshold = 33'd25;
        run_frame("skipdc", 2, 16, 4'd7, 33'd25, 1'b0);

        // Backpressure: result frozen and input blocked while unconsumed
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_stable", {ov[2], ir[2], pidx[2], pmag[2], abv[2]},
                {1'b1, 1'b0, 4'd7, 33'd25, 1'b0});
        end
        release_result("hold", 2);

        // Reset mid-scan: previous result (3, 40000, 1) must be cleared
        fill(10, 10);
        set_bin(5, 100, -50);
        threshold = 33'd0;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", ov[0],   1'b0);
        chk("midrst_peak_idx",  pidx[0], 4'd0);
        chk("midrst_peak_mag",  pmag[0], 33'd0);
        chk("midrst_in_ready",  ir[0],   1'b1);
        step();
        rst = 1'b0;
        step();

        // Next frame after the reset completes normally
        fill(10, 10);
        set_bin(5, 100, -50);
        threshold = 33'd0;
        run_frame("after_rst", 0, 16, 4'd5, 33'd12500, 1'b1);
        release_result("after_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Accepts one frame of N_BINS complex FFT bins in parallel through a valid/ready handshake.
- Scans the frame sequentially, LANES bins per cycle, and computes the exact squared magnitude re²+im² of each bin.
- Reports the index and magnitude of the largest bin, plus a threshold-exceeded flag, through an output valid/ready handshake.
- Sits between the FFT core and the downstream tone/frequency decision logic. It is the parametrised successor of the fixed 16-bin analyzer.

Parameters:
- N_BINS, 16, number of bins per frame; power of two, 4..256.
- HALF_W, 16, width of each real/imag component, signed.
- LANES, 1, bins evaluated per scan cycle; must divide N_BINS.
- SKIP_DC, 0, 1 excludes bin 0 from the search.
- IDX_W, $clog2(N_BINS), width of index outputs.
- MAG_W, 2*HALF_W+1, magnitude width, unsigned, lossless.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  frame available.
- in_ready  out  1  block can accept a frame.
- in_data  in  N_BINS*2*HALF_W  bin k at [k*2*HALF_W +: 2*HALF_W]; real in the upper HALF_W bits, imag in the lower HALF_W bits, two's complement.
- threshold  in  MAG_W  detection threshold; sampled on frame accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- peak_idx  out  IDX_W  index of the maximum bin.
- peak_mag  out  MAG_W  re²+im² of that bin.
- above_thr  out  1  peak_mag > threshold (strict).

Behaviour:
- Reset values: state IDLE; in_ready=1 (derived from state); out_valid=0; peak_idx=0; peak_mag=0; above_thr=0; scan counter=0; frame buffer and threshold register=0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.
- Magnitude: each component is sign-extended, squared, and summed into MAG_W bits with no truncation.
  - (-2^(HALF_W-1))² + (-2^(HALF_W-1))² = 2^(2*HALF_W-1), which fits in MAG_W.
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data and threshold, set cnt=0, best_mag=0, best_idx=FIRST (FIRST = SKIP_DC ? 1 : 0), go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle evaluates bins cnt*LANES .. cnt*LANES+LANES-1.
  - Lanes reduce in ascending index order. best is replaced only when a candidate magnitude is strictly greater, so on ties the lowest index wins.
  - With SKIP_DC=1, bin 0 is masked out as a candidate.
  - cnt increments each cycle. On the cycle where cnt = N_BINS/LANES-1:
    - load peak_idx and peak_mag from the final reduction (including this cycle's lanes);
    - set above_thr = final mag > captured threshold;
    - set out_valid=1 and go to HOLD.
- HOLD:
  - out_valid=1, and outputs stay stable until out_ready=1.
  - On out_ready=1: out_valid drops on the next edge and the state goes to IDLE.
  - No new frame is accepted in the handoff cycle.
- Latency: out_valid rises exactly N_BINS/LANES cycles after the accepting edge. Throughput is one frame per N_BINS/LANES+2 cycles when out_ready is held high.
- in_data and threshold changes during SCAN/HOLD are ignored.
- All-zero frame: peak_idx=FIRST, peak_mag=0, above_thr=0.
- threshold = all-ones: above_thr is always 0.
- rst asserted mid-SCAN or mid-HOLD: immediately returns to the reset values. The in-flight frame is discarded and no partial result is presented.
- out_ready held high while in IDLE or SCAN has no effect.

Decomposition:
- Package fft_peak_pkg contains:
  - the state enum (IDLE, SCAN, HOLD);
  - function mag_width(half_w);
  - function bin_slice helper for in_data indexing.
- Sub-module bin_magnitude (combinational; HALF_W in, MAG_W out), instantiated LANES times.
- The lane reduction and FSM stay in the top module.

Test Plan:
- Basic scan: N_BINS=16, LANES=1; bin 5 = (re=100, im=-50), all other bins = (10,10), threshold=0.
  - Required: out_valid 16 cycles after accept; peak_idx=5; peak_mag=12500; above_thr=1.
- Tie break: bins 3 and 9 both (200,0), rest (0,0).
  - Required: peak_idx=3, peak_mag=40000.
- Extremes, LANES=4: bin 15 = (-32768,-32768), rest (32767,0).
  - Required: peak_idx=15; peak_mag=2147483648 (33-bit); latency 4 cycles.
- SKIP_DC=1: bin 0 = (1000,0), bin 7 = (3,4), rest zero.
  - Required: peak_idx=7, peak_mag=25.
- Backpressure and threshold: hold out_ready=0 for 10 cycles after out_valid.
  - Required: outputs stable and in_ready=0 throughout.
  - With threshold=25 and peak 25: above_thr=0.
  - After out_ready: out_valid clears, in_ready returns to 1.
- Reset mid-SCAN: assert rst at scan cycle 6.
  - Required: out_valid=0, peak_idx=0, peak_mag=0, in_ready=1.
  - The next frame completes normally with the correct result.
